// File: rtl/vram_loader_if.sv
// rtl/vram_loader_if.sv - image ROM read port and video RAM write port bundle
interface vram_loader_if #(
  parameter int ROM_AW  = 12,
  parameter int VRAM_AW = 11,
  parameter int DW      = 8
);
  logic [ROM_AW-1:0]  rom_ad;
  logic [DW-1:0]      rom_data;
  logic               vram_ce;
  logic [VRAM_AW-1:0] vram_ad;
  logic [DW-1:0]      vram_data;

  modport master (output rom_ad, vram_ce, vram_ad, vram_data, input rom_data);
  modport slave  (input rom_ad, vram_ce, vram_ad, vram_data, output rom_data);
endinterface

// File: rtl/vram_loader.sv
// rtl/vram_loader.sv - rectangle copy engine from image ROM into video RAM
module vram_loader #(
  parameter int ROM_AW     = 12,
  parameter int VRAM_AW    = 11,
  parameter int DW         = 8,
  parameter int WIDTH      = 64,
  parameter int HEIGHT     = 32,
  parameter int SRC_STRIDE = 64,
  parameter int DST_STRIDE = 64,
  parameter int SRC_BASE   = 0,
  parameter int DST_BASE   = 0,
  parameter bit AUTO_START = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          wr_allow,
  output logic          busy,
  output logic          done,
  vram_loader_if.master bus
);
  localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [XW-1:0]      X_LAST   = XW'(WIDTH - 1);
  localparam logic [YW-1:0]      Y_LAST   = YW'(HEIGHT - 1);
  localparam logic [ROM_AW-1:0]  SRC_B    = ROM_AW'(SRC_BASE);
  localparam logic [VRAM_AW-1:0] DST_B    = VRAM_AW'(DST_BASE);
  localparam logic [ROM_AW-1:0]  SRC_STEP = ROM_AW'(SRC_STRIDE);
  localparam logic [VRAM_AW-1:0] DST_STEP = VRAM_AW'(DST_STRIDE);

  typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

  state_t             state_q, state_d;
  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [ROM_AW-1:0]  src_row_q, src_row_d;
  logic [VRAM_AW-1:0] dst_row_q, dst_row_d;
  logic               armed_q, armed_d;
  logic [ROM_AW-1:0]  rom_ad_q, rom_ad_d;
  logic               vram_ce_q, vram_ce_d;
  logic [VRAM_AW-1:0] vram_ad_q, vram_ad_d;
  logic [DW-1:0]      vram_data_q, vram_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      src_row_q   <= SRC_B;
      dst_row_q   <= DST_B;
      armed_q     <= AUTO_START;
      rom_ad_q    <= SRC_B;
      vram_ce_q   <= 1'b0;
      vram_ad_q   <= DST_B;
      vram_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      src_row_q   <= src_row_d;
      dst_row_q   <= dst_row_d;
      armed_q     <= armed_d;
      rom_ad_q    <= rom_ad_d;
      vram_ce_q   <= vram_ce_d;
      vram_ad_q   <= vram_ad_d;
      vram_data_q <= vram_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Every output is a register; this block computes their next values.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    src_row_d   = src_row_q;
    dst_row_d   = dst_row_q;
    armed_d     = armed_q;
    rom_ad_d    = rom_ad_q;
    vram_ce_d   = 1'b0;
    vram_ad_d   = vram_ad_q;
    vram_data_d = vram_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start || armed_q) begin
          armed_d   = 1'b0;
          x_d       = '0;
          y_d       = '0;
          src_row_d = SRC_B;
          dst_row_d = DST_B;
          rom_ad_d  = SRC_B;
          busy_d    = 1'b1;
          state_d   = FETCH;
        end
      end
      FETCH: state_d = WRITE;
      WRITE: begin
        // With the permit low the ROM address is held, so rom_data stays valid.
        if (wr_allow) begin
          vram_ce_d   = 1'b1;
          vram_ad_d   = dst_row_q + VRAM_AW'(x_q);
          vram_data_d = bus.rom_data;
          state_d     = FETCH;
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              state_d = DONE;
            end else begin
              x_d       = '0;
              y_d       = y_q + 1'b1;
              src_row_d = src_row_q + SRC_STEP;
              dst_row_d = dst_row_q + DST_STEP;
              rom_ad_d  = src_row_q + SRC_STEP;
            end
          end else begin
            x_d      = x_q + 1'b1;
            rom_ad_d = rom_ad_q + 1'b1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.rom_ad    = rom_ad_q;
  assign bus.vram_ce   = vram_ce_q;
  assign bus.vram_ad   = vram_ad_q;
  assign bus.vram_data = vram_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: doc/vram_loader.md
# vram_loader

Rectangle copy engine that fills the video RAM write port from the image ROM. Sits directly upstream of the video RAM in the LCD display path: it walks a WIDTH×HEIGHT window of the ROM image, reads one byte at a time through the ROM's registered read port, and writes each byte to the corresponding video RAM address. Writes are gated by a permit input so the display logic can restrict them to blanking. Runs once automatically after reset (optional) and again on each `start` pulse.

## Interface
- `ROM_AW`, 12: image ROM address width.
- `VRAM_AW`, 11: video RAM write address width.
- `DW`, 8: data width.
- `WIDTH`, 64: pixels per copied row (≥1).
- `HEIGHT`, 32: copied rows (≥1).
- `SRC_STRIDE`, 64: ROM address step between rows.
- `DST_STRIDE`, 64: VRAM address step between rows.
- `SRC_BASE`, 0: ROM address of pixel (0,0).
- `DST_BASE`, 0: VRAM address of pixel (0,0).
- `AUTO_START`, 1: 1 = begin a copy on the first cycle after reset deasserts.

Ports:
- `clk` in 1: single clock for the block; all logic on posedge.
- `reset` in 1: synchronous, active-high reset.
- `start` in 1: request a copy; sampled only in IDLE.
- `wr_allow` in 1: write permit (e.g. display blanking); 0 stalls the copy.
- `rom_ad` out ROM_AW: image ROM read address, registered.
- `rom_data` in DW: ROM read data, valid one cycle after `rom_ad` changes.
- `vram_ce` out 1: video RAM write strobe, registered, one cycle per pixel.
- `vram_ad` out VRAM_AW: video RAM write address, registered.
- `vram_data` out DW: video RAM write data, registered.
- `busy` out 1: copy in progress.
- `done` out 1: one-cycle pulse after the last pixel's write.

## Operation
- States: IDLE, FETCH, WRITE, DONE. Internal counters `x` (0..WIDTH-1), `y` (0..HEIGHT-1), row bases `src_row`, `dst_row`, flag `armed`.
- Reset: state IDLE, `armed`=AUTO_START, `rom_ad`=SRC_BASE, `vram_ad`=DST_BASE, `vram_data`=0, `vram_ce`=0, `busy`=0, `done`=0, x=y=0.
- IDLE: if `start` or `armed`: clear `armed`, x=y=0, `src_row`=SRC_BASE, `dst_row`=DST_BASE, `rom_ad`=SRC_BASE, `busy`=1, go FETCH. Otherwise stay.
- FETCH: one wait cycle for ROM latency; `vram_ce`=0; go WRITE.
- WRITE, `wr_allow`=0: `vram_ce`=0, hold everything (`rom_ad` held, so `rom_data` stays valid), stay.
- WRITE, `wr_allow`=1: `vram_ce`=1, `vram_ad`=`dst_row`+x, `vram_data`=`rom_data`. If x=WIDTH-1 and y=HEIGHT-1 go DONE. Else if x=WIDTH-1: x=0, y+1, `src_row`+=SRC_STRIDE, `dst_row`+=DST_STRIDE, `rom_ad`=new `src_row`. Else x+1, `rom_ad`+1. Go FETCH.
- DONE: `vram_ce`=0, `done`=1, `busy`=0, go IDLE. `done` is 0 in every other state.
- Arithmetic: all address sums truncate modulo 2^ROM_AW / 2^VRAM_AW (wrap, no error).
- `start` while busy or in DONE: ignored, not queued.

## Timing
- `start` high at edge E0 (IDLE) → `busy`=1 after E0; first `vram_ce` high in the cycle after E2 (wr_allow=1).
- Throughput: one pixel per 2 cycles with `wr_allow` held high; each low WRITE cycle adds one cycle.
- Uninterrupted copy: `busy` high for 2·WIDTH·HEIGHT+1 cycles; `done` high the cycle after the last `vram_ce`, coincident with `busy` falling.
- `vram_ce` never high two consecutive cycles; `vram_ad`/`vram_data` stable while `vram_ce` is high.
- `reset` overrides everything, including a same-cycle `start`; reset mid-copy aborts with no further writes, then re-arms per AUTO_START.
- New `start` accepted earliest the cycle after `done`.

## Test plan
- AUTO_START=1, WIDTH=4, HEIGHT=2, SRC_STRIDE=8, DST_STRIDE=4, ROM model data=address[7:0], `wr_allow`=1 → 8 writes: VRAM 0..3 ← 0..3, VRAM 4..7 ← 8..11; `done` once, 17 busy cycles.
- AUTO_START=0, reset released, `start` never asserted → no `vram_ce`, `busy`=0, outputs at reset values indefinitely.
- `wr_allow` toggled 3-low/1-high during copy → identical address/data sequence to test 1, `vram_ce` only in cycles after `wr_allow`=1 in WRITE.
- `start` pulsed during busy and in the DONE cycle → ignored; second `start` in IDLE → second identical copy.
- `reset` asserted after the 3rd write → no further `vram_ce`; with AUTO_START=1 copy restarts from VRAM 0 ← ROM 0.
- SRC_BASE=4094, WIDTH=4, HEIGHT=1, ROM_AW=12 → ROM addresses 4094, 4095, 0, 1 (wrap).
